// File: rtl/dmem_dump_reader_pkg.sv
// rtl/dmem_dump_reader_pkg.sv - shared state encoding and constants for the dump reader
package dmem_dump_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/dmem_dump_reader_if.sv
// rtl/dmem_dump_reader_if.sv - data-memory read port and byte stream bundle
interface dmem_dump_reader_if #(
  parameter int ADDR_W = 10
);

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic [7:0]        out_byte;
  logic              out_valid;
  logic              out_ready;

  // The dump reader drives the memory request and the byte stream
  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rdata,
    output out_byte,
    output out_valid,
    input  out_ready
  );

  // Memory and byte sink side
  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rdata,
    input  out_byte,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/dmem_dump_reader.sv
// rtl/dmem_dump_reader.sv - reads a run of memory words and streams them MSB byte first
module dmem_dump_reader
  import dmem_dump_reader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  dmem_dump_reader_if.master bus
);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] shift;
  logic [1:0]        byte_idx;
  logic              handshake;
  logic              last_byte;

  assign handshake = (state == S_SEND) && bus.out_ready;
  assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Address, word count, byte index and shift register; address wraps naturally
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_addr  <= '0;
      remaining <= '0;
      shift     <= '0;
      byte_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (word_count != '0)) begin
            cur_addr  <= base_addr;
            remaining <= word_count;
          end
        end
        S_WAIT: begin
          shift    <= bus.mem_rdata;
          byte_idx <= '0;
        end
        S_SEND: begin
          if (handshake) begin
            shift    <= {shift[DATA_W-9:0], 8'h00};
            byte_idx <= byte_idx + 2'd1;
            if (last_byte) begin
              remaining <= remaining - 1'b1;
              cur_addr  <= cur_addr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and Moore outputs; every output is zero in IDLE so reset clears them
  always_comb begin
    state_nx      = state;
    busy          = 1'b0;
    done          = 1'b0;
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = '0;
    bus.out_valid = 1'b0;
    bus.out_byte  = 8'h00;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = (word_count != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        busy          = 1'b1;
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = cur_addr;
        state_nx      = S_WAIT;
      end
      S_WAIT: begin
        busy     = 1'b1;
        state_nx = S_SEND;
      end
      S_SEND: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_byte  = shift[DATA_W-1:DATA_W-8];
        if (handshake && last_byte) begin
          state_nx = (remaining == CNT_W'(1)) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
